// File: rtl/sa_tile_scheduler_pkg.sv
// Shared types and limits for the systolic-array tile scheduler.
package sa_tile_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_DRAIN,
        S_WB,
        S_NEXT
    } sched_state_t;

    localparam int SA_MAX_K = 128;
    localparam int SA_K_W   = 8;
    localparam int SA_IDX_W = 3;
    localparam int SA_CNT_W = 4;

    localparam logic [SA_CNT_W-1:0] SA_TILE_MAX = 4'd8;

endpackage

// File: rtl/sa_tile_counter.sv
// Row/column tile index walker: column advances first, wraps into the next row.
module sa_tile_counter
    import sa_tile_scheduler_pkg::*;
(
    input  logic                I_CLK,
    input  logic                I_RST,
    input  logic                I_CLR,
    input  logic                I_ADV,
    input  logic [SA_CNT_W-1:0] I_RT,
    input  logic [SA_CNT_W-1:0] I_CT,
    output logic [SA_IDX_W-1:0] O_ROW,
    output logic [SA_IDX_W-1:0] O_COL,
    output logic                O_LAST
);

    logic col_wrap;

    assign col_wrap = ({1'b0, O_COL} == (I_CT - 4'd1));
    assign O_LAST   = col_wrap && ({1'b0, O_ROW} == (I_RT - 4'd1));

    always_ff @(posedge I_CLK) begin
        if (I_RST || I_CLR) begin
            O_ROW <= '0;
            O_COL <= '0;
        end else if (I_ADV && !O_LAST) begin
            if (col_wrap) begin
                O_COL <= '0;
                O_ROW <= O_ROW + 3'd1;
            end else begin
                O_COL <= O_COL + 3'd1;
            end
        end
    end

endmodule

// File: rtl/sa_tile_scheduler.sv
// Job-level sequencer for a systolic array: walks RT x CT output tiles,
// streaming K operands, draining the array and handing off each result.
module sa_tile_scheduler
    import sa_tile_scheduler_pkg::*;
#(
    parameter int X_R       = 16,
    parameter int W_C       = 16,
    parameter int MAX_K     = SA_MAX_K,
    parameter int DRAIN_CYC = X_R + W_C - 1
) (
    input  logic                I_CLK,
    input  logic                I_RST,
    input  logic                I_CFG_VALID,
    output logic                O_CFG_READY,
    input  logic [SA_K_W-1:0]   I_CFG_K,
    input  logic [SA_CNT_W-1:0] I_CFG_RT,
    input  logic [SA_CNT_W-1:0] I_CFG_CT,
    input  logic                I_STALL,
    input  logic                I_ABORT,
    output logic                O_MGR_START,
    output logic                O_PE_SHIFT,
    output logic [SA_K_W-1:0]   O_M_DIM,
    input  logic                I_MGR_OVER,
    output logic [SA_IDX_W-1:0] O_ROW_TILE,
    output logic [SA_IDX_W-1:0] O_COL_TILE,
    output logic                O_RES_VALID,
    input  logic                I_RES_READY,
    output logic                O_DONE,
    output logic                O_ERR
);

    localparam int                 DRN_W      = $clog2(DRAIN_CYC + 1);
    localparam logic [DRN_W-1:0]   DRAIN_LAST = DRN_W'(DRAIN_CYC - 1);
    localparam logic [SA_K_W:0]    MAX_K_V    = (SA_K_W + 1)'(MAX_K);

    sched_state_t          state, state_nxt;
    logic [SA_K_W-1:0]     k_lat;
    logic [SA_CNT_W-1:0]   rt_lat, ct_lat;
    logic [SA_K_W-1:0]     shift_cnt;
    logic [DRN_W-1:0]      drain_cnt;
    logic                  mgr_over_p0;
    logic                  cfg_legal, wdog_hit, last_tile;
    logic                  accept, reject, wdog, tile_adv;

    assign cfg_legal = (I_CFG_K != '0) && ({1'b0, I_CFG_K} <= MAX_K_V)
                    && (I_CFG_RT != '0) && (I_CFG_RT <= SA_TILE_MAX)
                    && (I_CFG_CT != '0) && (I_CFG_CT <= SA_TILE_MAX);

    // Watchdog trips once K+2 shifts have gone out without the manager reporting completion.
    assign wdog_hit = ({1'b0, shift_cnt} == ({1'b0, k_lat} + 9'd2));
    assign O_M_DIM  = k_lat;

    sa_tile_counter u_tile_counter (
        .I_CLK  (I_CLK),
        .I_RST  (I_RST),
        .I_CLR  (accept),
        .I_ADV  (tile_adv),
        .I_RT   (rt_lat),
        .I_CT   (ct_lat),
        .O_ROW  (O_ROW_TILE),
        .O_COL  (O_COL_TILE),
        .O_LAST (last_tile)
    );

    always_comb begin
        state_nxt   = state;
        O_CFG_READY = 1'b0;
        O_MGR_START = 1'b0;
        O_PE_SHIFT  = 1'b0;
        O_RES_VALID = 1'b0;
        O_DONE      = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        wdog        = 1'b0;
        tile_adv    = 1'b0;
        case (state)
            S_IDLE: begin
                O_CFG_READY = 1'b1;
                if (I_CFG_VALID) begin
                    if (cfg_legal) begin
                        accept    = 1'b1;
                        state_nxt = S_START;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_START: begin
                O_MGR_START = 1'b1;
                state_nxt   = S_FEED;
            end
            S_FEED: begin
                if (mgr_over_p0) begin
                    O_PE_SHIFT = !I_STALL;
                    state_nxt  = S_DRAIN;
                end else if (wdog_hit) begin
                    wdog      = 1'b1;
                    state_nxt = S_DRAIN;
                end else begin
                    O_PE_SHIFT = !I_STALL;
                end
            end
            S_DRAIN: begin
                O_PE_SHIFT = !I_STALL;
                if (!I_STALL && (drain_cnt == DRAIN_LAST))
                    state_nxt = S_WB;
            end
            S_WB: begin
                O_RES_VALID = 1'b1;
                if (I_RES_READY)
                    state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (last_tile) begin
                    O_DONE    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    tile_adv  = 1'b1;
                    state_nxt = S_START;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort cuts streaming and result hand-off in the same cycle it is seen.
        if ((state != S_IDLE) && I_ABORT) begin
            state_nxt   = S_IDLE;
            O_PE_SHIFT  = 1'b0;
            O_RES_VALID = 1'b0;
            O_DONE      = 1'b0;
            tile_adv    = 1'b0;
            wdog        = 1'b0;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state       <= S_IDLE;
            k_lat       <= '0;
            rt_lat      <= '0;
            ct_lat      <= '0;
            shift_cnt   <= '0;
            drain_cnt   <= '0;
            mgr_over_p0 <= 1'b0;
            O_ERR       <= 1'b0;
        end else begin
            state       <= state_nxt;
            // Completion flag only counts while feeding, so a stale level from the previous tile is ignored.
            mgr_over_p0 <= (state == S_FEED) && I_MGR_OVER;
            if (accept) begin
                k_lat  <= I_CFG_K;
                rt_lat <= I_CFG_RT;
                ct_lat <= I_CFG_CT;
                O_ERR  <= 1'b0;
            end else if (reject || wdog) begin
                O_ERR  <= 1'b1;
            end
            if (state == S_START)
                shift_cnt <= '0;
            else if ((state == S_FEED) && O_PE_SHIFT)
                shift_cnt <= shift_cnt + 8'd1;
            if (state != S_DRAIN)
                drain_cnt <= '0;
            else if (O_PE_SHIFT)
                drain_cnt <= drain_cnt + 1'b1;
        end
    end

endmodule
